// File: rtl/operand_issuer_pkg.sv
// -----------------------------------------------------------------------------
// operand_issuer_pkg
//   Shared definitions for the operand issuer slice: FSM state encoding,
//   default operand/result widths and the completed-transaction counter width.
// -----------------------------------------------------------------------------
package operand_issuer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        DELIVER  = 2'd3
    } state_e;

    localparam int OP_W_DEF   = 1;
    localparam int RES_W_DEF  = 2;
    localparam int DONE_CNT_W = 16;

endpackage

// File: rtl/issuer_ch.sv
// -----------------------------------------------------------------------------
// issuer_ch
//   Single-entry master-channel holding register. A load captures the operand
//   and raises the pend flag; the flag (which is the channel's tvalid) and the
//   data stay put until the downstream handshake clears the flag.
//
// Ports:
//   clk, arst_n   clock, asynchronous active-low reset
//   load_i        capture data_i and mark the channel pending
//   data_i        operand to capture
//   ready_i       downstream tready
//   valid_o       downstream tvalid (the registered pend flag)
//   data_o        downstream tdata (registered, held while pending)
//   pend_d_o      pend flag value after this cycle's load/handshake
// -----------------------------------------------------------------------------
module issuer_ch #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         pend_d_o
);

    logic         pend_q, pend_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        pend_d = pend_q;
        data_d = data_q;
        if (load_i) begin
            pend_d = 1'b1;
            data_d = data_i;
        end else if (pend_q && ready_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend_q <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

    assign valid_o  = pend_q;
    assign data_o   = data_q;
    assign pend_d_o = pend_d;

endmodule

// File: rtl/operand_issuer.sv
// -----------------------------------------------------------------------------
// operand_issuer
//   Accepts one packed operand pair {B, A}, issues A and B on two independent
//   master streams, waits for the arithmetic unit's result, and forwards it.
//   One transaction in flight at a time; a watchdog raises a sticky flag if
//   the unit takes TIMEOUT or more cycles to answer.
//
// Ports:
//   clk, arst_n                              clock, async active-low reset
//   s_op_tdata/tvalid/tready                 packed operand input {B, A}
//   m_a_tdata/tvalid/tready                  operand A stream
//   m_b_tdata/tvalid/tready                  operand B stream
//   s_res_tdata/tvalid/tready                result returned by the unit
//   m_out_tdata/tvalid/tready                forwarded result
//   done_count                               completed transactions (wraps)
//   timeout_err                              sticky watchdog flag
// -----------------------------------------------------------------------------
module operand_issuer
    import operand_issuer_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [2*OP_W-1:0]     s_op_tdata,
    input  logic                  s_op_tvalid,
    output logic                  s_op_tready,
    output logic [OP_W-1:0]       m_a_tdata,
    output logic                  m_a_tvalid,
    input  logic                  m_a_tready,
    output logic [OP_W-1:0]       m_b_tdata,
    output logic                  m_b_tvalid,
    input  logic                  m_b_tready,
    input  logic [RES_W-1:0]      s_res_tdata,
    input  logic                  s_res_tvalid,
    output logic                  s_res_tready,
    output logic [RES_W-1:0]      m_out_tdata,
    output logic                  m_out_tvalid,
    input  logic                  m_out_tready,
    output logic [DONE_CNT_W-1:0] done_count,
    output logic                  timeout_err
);

    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

    state_e                  state_q;
    logic [RES_W-1:0]        res_q;
    logic [DONE_CNT_W-1:0]   done_q;
    logic [15:0]             wd_q;
    logic [15:0]             wd_d;
    logic                    err_q;

    logic                    op_load;
    logic                    a_pend_d, b_pend_d;

    // Operand pair is only taken in IDLE, so a load never collides with a
    // pending channel.
    assign op_load = (state_q == IDLE) && s_op_tvalid;

    issuer_ch #(.W(OP_W)) u_ch_a (
        .clk      (clk),
        .arst_n   (arst_n),
        .load_i   (op_load),
        .data_i   (s_op_tdata[OP_W-1:0]),
        .ready_i  (m_a_tready),
        .valid_o  (m_a_tvalid),
        .data_o   (m_a_tdata),
        .pend_d_o (a_pend_d)
    );

    issuer_ch #(.W(OP_W)) u_ch_b (
        .clk      (clk),
        .arst_n   (arst_n),
        .load_i   (op_load),
        .data_i   (s_op_tdata[2*OP_W-1:OP_W]),
        .ready_i  (m_b_tready),
        .valid_o  (m_b_tvalid),
        .data_o   (m_b_tdata),
        .pend_d_o (b_pend_d)
    );

    // Saturating watchdog increment.
    assign wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            done_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_op_tvalid) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Leave once both channels are drained, counting any
                    // handshake that lands in this very cycle.
                    if (!a_pend_d && !b_pend_d) begin
                        state_q <= WAIT_RES;
                        wd_q    <= '0;
                    end
                end
                WAIT_RES: begin
                    wd_q <= wd_d;
                    // Flag is raised together with the counter reaching
                    // TIMEOUT; the FSM keeps waiting regardless.
                    if (wd_d == TIMEOUT_L) begin
                        err_q <= 1'b1;
                    end
                    if (s_res_tvalid) begin
                        res_q   <= s_res_tdata;
                        state_q <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (m_out_tready) begin
                        done_q  <= done_q + 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake readies/valids are pure decodes of the registered state.
    assign s_op_tready  = (state_q == IDLE);
    assign s_res_tready = (state_q == WAIT_RES);
    assign m_out_tvalid = (state_q == DELIVER);
    assign m_out_tdata  = res_q;
    assign done_count   = done_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_operand_issuer.sv
// -----------------------------------------------------------------------------
// tb_operand_issuer
//   Directed bench for operand_issuer (OP_W=1, RES_W=2, TIMEOUT=8). The bench
//   plays the role of the half-adder unit where a responder is needed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_operand_issuer;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [1:0]  s_op_tdata;
    logic        s_op_tvalid;
    logic        s_op_tready;
    logic [0:0]  m_a_tdata;
    logic        m_a_tvalid;
    logic        m_a_tready;
    logic [0:0]  m_b_tdata;
    logic        m_b_tvalid;
    logic        m_b_tready;
    logic [1:0]  s_res_tdata;
    logic        s_res_tvalid;
    logic        s_res_tready;
    logic [1:0]  m_out_tdata;
    logic        m_out_tvalid;
    logic        m_out_tready;
    logic [15:0] done_count;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    operand_issuer #(.OP_W(1), .RES_W(2), .TIMEOUT(8)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .s_op_tdata   (s_op_tdata),
        .s_op_tvalid  (s_op_tvalid),
        .s_op_tready  (s_op_tready),
        .m_a_tdata    (m_a_tdata),
        .m_a_tvalid   (m_a_tvalid),
        .m_a_tready   (m_a_tready),
        .m_b_tdata    (m_b_tdata),
        .m_b_tvalid   (m_b_tvalid),
        .m_b_tready   (m_b_tready),
        .s_res_tdata  (s_res_tdata),
        .s_res_tvalid (s_res_tvalid),
        .s_res_tready (s_res_tready),
        .m_out_tdata  (m_out_tdata),
        .m_out_tvalid (m_out_tvalid),
        .m_out_tready (m_out_tready),
        .done_count   (done_count),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string pfx);
        check({pfx, "_s_op_tready"},  32'(s_op_tready),  32'd1);
        check({pfx, "_m_a_tvalid"},   32'(m_a_tvalid),   32'd0);
        check({pfx, "_m_b_tvalid"},   32'(m_b_tvalid),   32'd0);
        check({pfx, "_m_a_tdata"},    32'(m_a_tdata),    32'd0);
        check({pfx, "_m_b_tdata"},    32'(m_b_tdata),    32'd0);
        check({pfx, "_s_res_tready"}, 32'(s_res_tready), 32'd0);
        check({pfx, "_m_out_tvalid"}, 32'(m_out_tvalid), 32'd0);
        check({pfx, "_m_out_tdata"},  32'(m_out_tdata),  32'd0);
        check({pfx, "_done_count"},   32'(done_count),   32'd0);
        check({pfx, "_timeout_err"},  32'(timeout_err),  32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        check_reset_outs("rst");
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // Full transaction with all readies high; bench answers as a half adder.
    task automatic do_txn(input logic [1:0] ops, output logic [1:0] res);
        int   budget;
        logic a, b;
        res = 2'b00;
        budget = 0;
        while (!s_op_tready && budget < 20) begin tick(); budget++; end
        check("txn_op_ready", 32'(s_op_tready), 32'd1);
        s_op_tdata  = ops;
        s_op_tvalid = 1'b1;
        tick();
        s_op_tvalid = 1'b0;
        check("txn_issue_valid", 32'({m_a_tvalid, m_b_tvalid}), 32'd3);
        a = m_a_tdata[0];
        b = m_b_tdata[0];
        budget = 0;
        while (!s_res_tready && budget < 20) begin tick(); budget++; end
        check("txn_res_ready", 32'(s_res_tready), 32'd1);
        s_res_tdata  = {a & b, a ^ b};
        s_res_tvalid = 1'b1;
        tick();
        s_res_tvalid = 1'b0;
        budget = 0;
        while (!m_out_tvalid && budget < 20) begin tick(); budget++; end
        check("txn_out_valid", 32'(m_out_tvalid), 32'd1);
        res = m_out_tdata;
        tick();
        $display("[TB] txn ops=%b a=%b b=%b result=%b done_count=%0d", ops, a, b, res, done_count);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [1:0] r;
        logic [1:0] cl_ops [4];
        logic [1:0] cl_exp [4];
        cl_ops[0] = 2'b00; cl_exp[0] = 2'b00;  // A=0,B=0
        cl_ops[1] = 2'b01; cl_exp[1] = 2'b01;  // A=1,B=0
        cl_ops[2] = 2'b10; cl_exp[2] = 2'b01;  // A=0,B=1
        cl_ops[3] = 2'b11; cl_exp[3] = 2'b10;  // A=1,B=1

        arst_n       = 1'b0;
        s_op_tdata   = 2'b00;
        s_op_tvalid  = 1'b0;
        m_a_tready   = 1'b1;
        m_b_tready   = 1'b1;
        s_res_tdata  = 2'b00;
        s_res_tvalid = 1'b0;
        m_out_tready = 1'b1;
        #12;
        check_reset_outs("init");
        @(negedge clk);
        arst_n = 1'b1;
        tick();

        // ---- Basic transaction: ops 11, result 10 three cycles later ----
        s_op_tdata  = 2'b11;
        s_op_tvalid = 1'b1;
        tick();                                   // cycle 1
        s_op_tvalid = 1'b0;
        check("basic_a_valid", 32'(m_a_tvalid), 32'd1);
        check("basic_b_valid", 32'(m_b_tvalid), 32'd1);
        check("basic_a_data",  32'(m_a_tdata),  32'd1);
        check("basic_b_data",  32'(m_b_tdata),  32'd1);
        tick();                                   // cycle 2
        check("basic_res_ready", 32'(s_res_tready), 32'd1);
        check("basic_a_valid_off", 32'(m_a_tvalid), 32'd0);
        tick();                                   // cycle 3
        tick();                                   // cycle 4
        s_res_tdata  = 2'b10;
        s_res_tvalid = 1'b1;
        tick();                                   // cycle 5
        s_res_tvalid = 1'b0;
        check("basic_out_valid", 32'(m_out_tvalid), 32'd1);
        check("basic_out_data",  32'(m_out_tdata),  32'd2);
        tick();                                   // cycle 6
        check("basic_op_ready", 32'(s_op_tready), 32'd1);
        check("basic_done",     32'(done_count),  32'd1);
        check("basic_err",      32'(timeout_err), 32'd0);
        $display("[TB] basic ops=11 result=%b done_count=%0d", m_out_tdata, done_count);

        // ---- Skewed operand readies: B (=1) stalled until cycle 5 ----
        m_b_tready  = 1'b0;
        s_op_tdata  = 2'b10;
        s_op_tvalid = 1'b1;
        tick();                                   // cycle 1
        s_op_tvalid = 1'b0;
        check("skew_a_valid_c1", 32'(m_a_tvalid), 32'd1);
        check("skew_b_valid_c1", 32'(m_b_tvalid), 32'd1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check($sformatf("skew_a_valid_c%0d", c), 32'(m_a_tvalid), 32'd0);
            check($sformatf("skew_b_valid_c%0d", c), 32'(m_b_tvalid), 32'd1);
            check($sformatf("skew_b_data_c%0d", c),  32'(m_b_tdata),  32'd1);
            check($sformatf("skew_res_ready_c%0d", c), 32'(s_res_tready), 32'd0);
        end
        m_b_tready = 1'b1;                        // handshake in cycle 5
        tick();                                   // cycle 6
        check("skew_res_ready_c6", 32'(s_res_tready), 32'd1);
        check("skew_b_valid_c6",   32'(m_b_tvalid),   32'd0);
        s_res_tdata  = 2'b01;
        s_res_tvalid = 1'b1;
        tick();
        s_res_tvalid = 1'b0;
        check("skew_out_data", 32'(m_out_tdata), 32'd1);
        tick();
        check("skew_done", 32'(done_count), 32'd2);
        $display("[TB] skew ops=10 result=01 done_count=%0d", done_count);

        // ---- Output backpressure with a second pair offered ----
        m_out_tready = 1'b0;
        s_op_tdata   = 2'b01;
        s_op_tvalid  = 1'b1;
        tick();                                   // cycle 1 (ISSUE)
        s_op_tvalid = 1'b0;
        tick();                                   // cycle 2 (WAIT_RES)
        s_res_tdata  = 2'b01;
        s_res_tvalid = 1'b1;
        tick();                                   // cycle 3 (DELIVER)
        s_res_tvalid = 1'b0;
        s_op_tdata   = 2'b11;
        s_op_tvalid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("bp_out_valid_%0d", c), 32'(m_out_tvalid), 32'd1);
            check($sformatf("bp_out_data_%0d", c),  32'(m_out_tdata),  32'd1);
            check($sformatf("bp_op_ready_%0d", c),  32'(s_op_tready),  32'd0);
            tick();
        end
        m_out_tready = 1'b1;                      // handshake in this cycle
        check("bp_out_valid_hs", 32'(m_out_tvalid), 32'd1);
        check("bp_op_ready_hs",  32'(s_op_tready),  32'd0);
        tick();
        check("bp_op_ready_after", 32'(s_op_tready), 32'd1);
        check("bp_done",           32'(done_count),  32'd3);
        tick();                                   // second pair issued
        s_op_tvalid = 1'b0;
        check("bp2_a_data", 32'(m_a_tdata), 32'd1);
        check("bp2_b_data", 32'(m_b_tdata), 32'd1);
        tick();
        s_res_tdata  = 2'b10;
        s_res_tvalid = 1'b1;
        tick();
        s_res_tvalid = 1'b0;
        check("bp2_out_data", 32'(m_out_tdata), 32'd2);
        tick();
        check("bp2_done", 32'(done_count), 32'd4);
        $display("[TB] backpressure pairs=01,11 done_count=%0d", done_count);

        // ---- Timeout: no result for 12 WAIT_RES cycles ----
        s_op_tdata  = 2'b01;
        s_op_tvalid = 1'b1;
        tick();                                   // cycle 1
        s_op_tvalid = 1'b0;
        tick();                                   // cycle 2: first WAIT_RES cycle
        for (int k = 0; k <= 12; k++) begin
            check($sformatf("to_err_after_%0d", k), 32'(timeout_err), (k >= 8) ? 32'd1 : 32'd0);
            check($sformatf("to_res_ready_%0d", k), 32'(s_res_tready), 32'd1);
            if (k < 12) tick();
        end
        s_res_tdata  = 2'b01;
        s_res_tvalid = 1'b1;
        tick();
        s_res_tvalid = 1'b0;
        check("to_out_valid", 32'(m_out_tvalid), 32'd1);
        check("to_out_data",  32'(m_out_tdata),  32'd1);
        tick();
        check("to_done",      32'(done_count),  32'd5);
        check("to_err_stick", 32'(timeout_err), 32'd1);
        $display("[TB] timeout result=01 done_count=%0d timeout_err=%0d", done_count, timeout_err);

        // ---- Reset mid-ISSUE while B is still pending ----
        m_b_tready  = 1'b0;
        s_op_tdata  = 2'b11;
        s_op_tvalid = 1'b1;
        tick();
        s_op_tvalid = 1'b0;
        tick();
        check("rmid_b_valid", 32'(m_b_tvalid), 32'd1);
        do_reset();
        m_b_tready = 1'b1;
        do_txn(2'b10, r);
        check("rmid_next_res",  32'(r),          32'd1);
        check("rmid_next_done", 32'(done_count), 32'd1);

        // ---- Closed loop, four back-to-back pairs ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_txn(cl_ops[i], r);
            check($sformatf("loop_res_%0d", i), 32'(r), 32'(cl_exp[i]));
        end
        check("loop_done", 32'(done_count), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_issuer.md
# operand_issuer

Stream initiator that drives the operand side of the stream arithmetic units: the 1-bit half-adder unit and, later, the Vedic multiplier stages. It accepts one packed operand pair on a slave stream and presents operand A and operand B on two independent master streams. It then collects the unit's result stream and forwards the result downstream. Only one transaction is outstanding at a time, and a timeout watchdog flags a unit that stops responding.

## Interface
Parameters:
- OP_W, default 1: width of each operand.
- RES_W, default 2: width of the result.
- TIMEOUT, default 255: number of WAIT_RES cycles before timeout_err is set. Range 1 to 65535.

Ports:
- clk, in, 1: clock.
- arst_n, in, 1: reset, asynchronous, active-low.
- s_op_tdata, in, 2*OP_W: packed operands {B, A}, with A in the LSBs.
- s_op_tvalid, in, 1; s_op_tready, out, 1: operand input handshake.
- m_a_tdata, out, OP_W; m_a_tvalid, out, 1; m_a_tready, in, 1: operand A stream.
- m_b_tdata, out, OP_W; m_b_tvalid, out, 1; m_b_tready, in, 1: operand B stream.
- s_res_tdata, in, RES_W; s_res_tvalid, in, 1; s_res_tready, out, 1: result stream returned by the unit.
- m_out_tdata, out, RES_W; m_out_tvalid, out, 1; m_out_tready, in, 1: forwarded result.
- done_count, out, 16: number of completed transactions; wraps from 0xFFFF to 0.
- timeout_err, out, 1: sticky watchdog flag.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT_RES and DELIVER.
- IDLE:
  - s_op_tready = 1.
  - On the s_op handshake: latch A and B, set a_pend = b_pend = 1, and go to ISSUE.
- ISSUE:
  - m_a_tvalid = a_pend and m_b_tvalid = b_pend.
  - A handshake on a channel clears that channel's pend flag.
  - When both flags are clear after this cycle's handshakes are applied, go to WAIT_RES. This covers simultaneous handshakes and a final handshake arriving in the same cycle.
  - Once a valid is asserted, the valid and its data stay stable until that channel's handshake.
- WAIT_RES:
  - s_res_tready = 1.
  - On the s_res handshake: latch the result and go to DELIVER.
- DELIVER:
  - m_out_tvalid = 1, and m_out_tdata holds the latched result.
  - On the m_out handshake: done_count increments and the FSM returns to IDLE.
- Each of s_op_tready, s_res_tready and m_out_tvalid is high exactly while the FSM is in its own state. They are registered, or decoded from the registered state; there is no combinational path from any input.
- Results offered outside WAIT_RES are not accepted. The producer holds them until WAIT_RES.
- Watchdog:
  - A 16-bit counter clears on entry to WAIT_RES and increments every WAIT_RES cycle, saturating.
  - When the counter equals TIMEOUT, timeout_err is set to 1.
  - timeout_err stays set until reset. The FSM keeps waiting, so a late result still completes normally.
- Result data is passed through unmodified; no width conversion is done.

## Timing
- All outputs reset to 0 except s_op_tready, which is 1 (FSM state IDLE). This includes m_*_tvalid, all tdata outputs, done_count and timeout_err.
- Reset takes effect immediately whenever arst_n falls, including mid-transaction. The in-flight transaction is discarded and is not counted.
- Cycle numbering takes the s_op handshake as cycle 0:
  - m_a_tvalid and m_b_tvalid are high from cycle 1.
  - With both operand readies high in cycle 1, s_res_tready is high from cycle 2.
  - After an s_res handshake in cycle N, m_out_tvalid is high in cycle N+1.
  - After an m_out handshake in cycle M, s_op_tready is high in cycle M+1.
- Minimum transaction period: 4 cycles plus the unit's response latency.
- done_count updates in the cycle after the m_out handshake.

## Structure
- Package operand_issuer_pkg holds:
  - the 2-bit state encodings IDLE = 0, ISSUE = 1, WAIT_RES = 2, DELIVER = 3;
  - defaults for OP_W and RES_W;
  - the done_count width (16).
- Sub-module issuer_ch is the single-entry master-channel holding register: load, pend flag, valid/data hold, and clear on handshake. It is instantiated twice, once for A and once for B.
- The top level contains the FSM, the result latch, the watchdog and the counter.

## Test plan
- Basic transaction:
  - Stimulus: s_op_tdata = 2'b11 with all readies high; the responder returns 2'b10 three cycles after both operand handshakes.
  - Response: m_out_tdata = 2'b10; done_count = 1; timeout_err = 0.
- Skewed operand readies:
  - Stimulus: m_a_tready = 1 in cycle 1; m_b_tready held low until cycle 5.
  - Response: m_a_tvalid drops in cycle 2; m_b_tvalid and m_b_tdata stay stable through cycle 5; s_res_tready rises in cycle 6.
- Output backpressure:
  - Stimulus: m_out_tready held low for 4 cycles while s_op_tvalid offers a second pair.
  - Response: m_out_tvalid and m_out_tdata are stable; s_op_tready stays 0 until the cycle after the m_out handshake.
- Timeout:
  - Stimulus: TIMEOUT = 8 and no result for 12 cycles, then s_res_tdata = 2'b01.
  - Response: timeout_err rises after the 8th WAIT_RES cycle; the result is still delivered; done_count increments; timeout_err remains 1.
- Reset mid-ISSUE:
  - Stimulus: arst_n pulsed low while m_b_tvalid = 1.
  - Response: all outputs take their reset values immediately; the next operand pair completes normally with done_count = 1.
- Closed loop with the half-adder stream unit:
  - Stimulus: four back-to-back pairs (A,B) = (0,0), (1,0), (0,1), (1,1).
  - Response: outputs 2'b00, 2'b01, 2'b01, 2'b10 in order; done_count = 4.
